// File: rtl/rs232_rx_fifo.sv
// First-word-fall-through byte FIFO behind the RS-232 receiver, with a sticky overflow flag.
// Define RS232_RX_FIFO_CTS_EN to drive rs232_ctsn_o from level hysteresis; otherwise it is tied to 0.
module rs232_rx_fifo #(
    parameter int ADDR_BITS     = 4,
    parameter int CTS_HIGH_MARK = 12,
    parameter int CTS_LOW_MARK  = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [7:0]           in_data_i,
    input  logic                 in_valid_i,
    output logic [7:0]           out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ADDR_BITS:0]   level_o,
    output logic                 overflow_o,
    input  logic                 overflow_clear_i,
    output logic                 rs232_ctsn_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_LEVEL = (ADDR_BITS + 1)'(DEPTH);

    logic [7:0]           mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   level_q, level_d;
    logic [7:0]           out_data_q;
    logic                 out_valid_q, out_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 push, pop, full, drop;

    always_comb begin
        pop  = out_valid_q & out_ready_i;
        full = (level_q == FULL_LEVEL);
        // When full, a pop in the same cycle frees the slot the new byte lands in.
        push = in_valid_i & (~full | pop);
        drop = in_valid_i & full & ~pop;

        wr_ptr_d = wr_ptr_q + ADDR_BITS'(push);
        rd_ptr_d = rd_ptr_q + ADDR_BITS'(pop);

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Only bytes written at an earlier edge are visible to the read port, so a byte
        // pushed into an empty FIFO becomes valid one edge after it was stored.
        out_valid_d = ((level_q - (ADDR_BITS + 1)'(pop)) != '0);

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clear_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            if (out_valid_d) begin
                out_data_q <= mem_q[rd_ptr_d];
            end
        end
    end

`ifdef RS232_RX_FIFO_CTS_EN
    localparam logic [ADDR_BITS:0] HIGH_LEVEL = (ADDR_BITS + 1)'(CTS_HIGH_MARK);
    localparam logic [ADDR_BITS:0] LOW_LEVEL  = (ADDR_BITS + 1)'(CTS_LOW_MARK);

    logic ctsn_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ctsn_q <= 1'b0;
        end else if (level_q >= HIGH_LEVEL) begin
            ctsn_q <= 1'b1;
        end else if (level_q <= LOW_LEVEL) begin
            ctsn_q <= 1'b0;
        end
    end

    assign rs232_ctsn_o = ctsn_q;
`else
    assign rs232_ctsn_o = 1'b0;
`endif

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Directed and randomized checks of rs232_rx_fifo against a queue-based model of its FIFO rules.
module tb_rs232_rx_fifo;

    localparam int DEPTH = 16;
    localparam int HIGH  = 12;
    localparam int LOW   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] level;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    logic       ctsn;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of stored bytes plus the flags the outputs must show.
    logic [7:0] q[$];
    bit         exp_valid = 1'b0;
    bit         exp_ovf   = 1'b0;
    bit         exp_cts   = 1'b0;

    rs232_rx_fifo dut (
        .clock_i          (clk),
        .reset_i          (rst),
        .in_data_i        (in_data),
        .in_valid_i       (in_valid),
        .out_data_o       (out_data),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .level_o          (level),
        .overflow_o       (overflow),
        .overflow_clear_i (ovf_clr),
        .rs232_ctsn_o     (ctsn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
        chk({tag, ".level"}, 32'(level), 32'(q.size()));
        chk({tag, ".ovf"},   32'(overflow), 32'(exp_ovf));
        chk({tag, ".ctsn"},  32'(ctsn), 32'(exp_cts));
        if (exp_valid) chk({tag, ".data"}, 32'(out_data), 32'(q[0]));
    endtask

    task automatic model_reset();
        q.delete();
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_cts   = 1'b0;
    endtask

    // Drive one cycle of inputs, advance one edge, update the model and compare.
    task automatic step(input string tag, input bit v, input logic [7:0] d, input bit rdy, input bit clr);
        int  sz;
        bit  pop, push;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        sz   = q.size();
        pop  = exp_valid && rdy;
        push = v && (sz < DEPTH || pop);
        if (v && !push) exp_ovf = 1'b1;
        else if (clr)   exp_ovf = 1'b0;
`ifdef RS232_RX_FIFO_CTS_EN
        if (sz >= HIGH)     exp_cts = 1'b1;
        else if (sz <= LOW) exp_cts = 1'b0;
`endif
        // A byte is presented only if it was already stored before this edge.
        exp_valid = (sz - int'(pop)) > 0;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(d);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] rd;
        // Reset state, held across edges.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.data", 32'(out_data), 32'h00);
        check_all("rst");
        rst = 1'b0;

        // Three bytes with consumer stalled, then drained back-to-back.
        step("t1.push", 1, 8'h41, 0, 0);
        step("t1.push", 1, 8'h42, 0, 0);
        step("t1.push", 1, 8'h43, 0, 0);
        step("t1.idle", 0, 8'h00, 0, 0);
        chk("t1.head", 32'(out_data), 32'h41);
        chk("t1.level", 32'(level), 32'd3);
        for (int i = 0; i < 3; i++) begin
            rd = out_data;
            chk("t2.seq", 32'(rd), 32'(8'h41 + i));
            step("t2.pop", 0, 8'h00, 1, 0);
        end
        chk("t2.empty", 32'(out_valid), 32'd0);
        chk("t2.level", 32'(level), 32'd0);

        // Seventeen bytes into a 16-deep FIFO, then full readout.
        for (int i = 0; i < 17; i++) step("t3.fill", 1, 8'(i), 0, 0);
        chk("t3.ovf", 32'(overflow), 32'd1);
        chk("t3.level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t3.seq", 32'(out_data), 32'(i));
            step("t3.drain", 0, 8'h00, 1, 0);
        end
        step("t3.clr", 0, 8'h00, 0, 1);

        // Full, with push and pop in the same cycle: no overflow, 0xAA lands last.
        for (int i = 0; i < 16; i++) step("t4.fill", 1, 8'(8'h80 + i), 0, 0);
        step("t4.both", 1, 8'hAA, 1, 0);
        chk("t4.ovf", 32'(overflow), 32'd0);
        chk("t4.level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) step("t4.drain", 0, 8'h00, 1, 0);

        // Empty with in_valid and out_ready together; clear racing a new drop.
        step("t5.emptyrdy", 1, 8'h5A, 1, 0);
        for (int i = 0; i < 16; i++) step("t5.fill", 1, 8'(i), 0, 0);
        step("t5.clrdrop", 1, 8'hEE, 0, 1);
        chk("t5.setwins", 32'(overflow), 32'd1);
        step("t5.clr", 0, 8'h00, 0, 1);
        for (int i = 0; i < 16; i++) step("t5.drain", 0, 8'h00, 1, 0);

        // Hysteresis sweep: fill to 13, drain down to 7 (model covers both builds).
        for (int i = 0; i < 13; i++) step("t6.fill", 1, 8'(i), 0, 0);
        step("t6.hold", 0, 8'h00, 0, 0);
        for (int i = 0; i < 6; i++) step("t6.drain", 0, 8'h00, 1, 0);
        step("t6.hold", 0, 8'h00, 0, 0);
        for (int i = 0; i < 7; i++) step("t6.drain", 0, 8'h00, 1, 0);

        // Randomized traffic with alternating fill/drain bias.
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 60; i++) begin
                bit v, r, c;
                v = (seg % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
                r = (seg % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
                c = ($urandom_range(0, 15) == 0);
                step("rand", v, 8'($urandom), r, c);
            end
        end

        // Asynchronous reset mid-burst with overflow set.
        for (int i = 0; i < 16; i++) step("t7.prep", 0, 8'h00, 1, 0);
        for (int i = 0; i < 17; i++) step("t7.fill", 1, 8'(8'hC0 + i), 0, 0);
        for (int i = 0; i < 11; i++) step("t7.drain", 1, 8'h00, 1, 0);
        for (int i = 0; i < 11; i++) step("t7.drain", 0, 8'h00, 1, 0);
        chk("t7.pre", 32'(level), 32'd5);
        rst = 1'b1;
        #2;
        model_reset();
        chk("t7.level", 32'(level), 32'd0);
        chk("t7.valid", 32'(out_valid), 32'd0);
        chk("t7.ovf", 32'(overflow), 32'd0);
        chk("t7.data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("t7.after", 1, 8'h77, 0, 0);
        step("t7.after", 0, 8'h00, 0, 0);
        step("t7.after", 0, 8'h00, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
